// File: rtl/neotrellis_pixel_scheduler_pkg.sv
// Shared types and seesaw NeoPixel register map for the NeoTrellis LED scheduler.
package neotrellis_pixel_scheduler_pkg;

   localparam int PX_IDX_W = 4;

   localparam logic [15:0] SEESAW_NEOPIXEL_PIN        = 16'h0E01;
   localparam logic [15:0] SEESAW_NEOPIXEL_BUF_LENGTH = 16'h0E03;
   localparam logic [15:0] SEESAW_NEOPIXEL_BUF        = 16'h0E04;
   localparam logic [15:0] SEESAW_NEOPIXEL_SHOW       = 16'h0E05;

   typedef enum logic [3:0] {
      ST_STARTUP,
      ST_INIT_PIN,
      ST_INIT_LEN,
      ST_IDLE,
      ST_PICK,
      ST_SHOW,
      ST_ISSUE,
      ST_WAIT_ACK,
      ST_WAIT_DONE,
      ST_FINISH
   } sched_state_t;

   typedef enum logic [1:0] {
      TXN_PIN,
      TXN_LEN,
      TXN_PIX,
      TXN_SHOW
   } txn_kind_t;

   typedef struct packed {
      logic [PX_IDX_W-1:0] idx;
      logic [23:0]         rgb;
   } pixel_wr_t;

   function automatic logic [39:0] buf_payload(input logic [15:0] offset, input logic [23:0] rgb);
      return {offset, rgb};
   endfunction

endpackage

// File: rtl/neotrellis_pixel_scheduler_if.sv
// Pixel-update request bus (UI side is master) and i2c_master control bus (scheduler is master).
interface neotrellis_px_if;
   logic        px_valid;
   logic        px_ready;
   logic [3:0]  px_index;
   logic [23:0] px_rgb;
   logic        flush;

   modport master (output px_valid, px_index, px_rgb, flush, input px_ready);
   modport slave  (input px_valid, px_index, px_rgb, flush, output px_ready);
endinterface

interface neotrellis_i2c_if;
   logic        i2c_enable;
   logic        i2c_read_write;
   logic [6:0]  i2c_device_address;
   logic [15:0] i2c_divider;
   logic [15:0] i2c_register_address;
   logic [39:0] i2c_mosi_data;
   logic        i2c_busy;

   modport master (output i2c_enable, i2c_read_write, i2c_device_address, i2c_divider,
                   i2c_register_address, i2c_mosi_data, input i2c_busy);
   modport slave  (input i2c_enable, i2c_read_write, i2c_device_address, i2c_divider,
                   i2c_register_address, i2c_mosi_data, output i2c_busy);
endinterface

// File: rtl/neotrellis_pixel_scheduler_rr_dirty_picker.sv
// Combinational circular priority encoder: first set dirty bit at or after rr_ptr_i.
module rr_dirty_picker #(
   parameter int NUM_PIXELS = 16,
   parameter int IDX_W      = $clog2(NUM_PIXELS)
) (
   input  logic [NUM_PIXELS-1:0] dirty_i,
   input  logic [IDX_W-1:0]      rr_ptr_i,
   output logic                  any_o,
   output logic [IDX_W-1:0]      idx_o
);

   always_comb begin
      int j;
      j     = 0;
      any_o = 1'b0;
      idx_o = '0;
      // Walk from the farthest slot back so the nearest one wins.
      for (int k = NUM_PIXELS - 1; k >= 0; k--) begin
         j = (int'(rr_ptr_i) + k) % NUM_PIXELS;
         if (dirty_i[j]) begin
            any_o = 1'b1;
            idx_o = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/neotrellis_pixel_scheduler.sv
// Owns the i2c_master: seesaw NeoPixel init, 16-pixel colour cache, round-robin dirty drain + SHOW.
// Pixel updates are always accepted (px_ready = !rst); enable follows an idle accept by >= 2 cycles.
module neotrellis_pixel_scheduler #(
   parameter int          NUM_PIXELS     = 16,
   parameter logic [6:0]  DEVICE_ADDR    = 7'h2E,
   parameter logic [15:0] I2C_DIVIDER    = 16'd29,
   parameter logic [7:0]  NEOPIXEL_PIN   = 8'd3,
   parameter int          STARTUP_CYCLES = 1_200_000,
   parameter int          ACK_TIMEOUT    = 1024,
   parameter int          MAX_BATCH      = 4
) (
   input  logic             clk,
   input  logic             rst,
   neotrellis_px_if.slave   px,
   neotrellis_i2c_if.master i2c,
   output logic             init_done_o,
   output logic             idle_o,
   output logic             error_o
);
   import neotrellis_pixel_scheduler_pkg::*;

   localparam int IDX_W   = $clog2(NUM_PIXELS);
   localparam int BATCH_W = $clog2(MAX_BATCH + 1);

   sched_state_t            state_q;
   txn_kind_t               kind_q;
   logic [31:0]             timer_q;
   logic [NUM_PIXELS-1:0]   dirty_q, dirty_d;
   logic [23:0]             rgb_q [NUM_PIXELS];
   logic [IDX_W-1:0]        rr_ptr_q;
   logic [BATCH_W-1:0]      batch_cnt_q;
   logic                    flush_pend_q, flush_pend_d;
   logic                    en_q, init_done_q, error_q;
   logic [15:0]             reg_q;
   logic [39:0]             mosi_q;

   pixel_wr_t               wr;
   logic [IDX_W-1:0]        wr_idx;
   logic                    accept;
   logic                    pick_any;
   logic [IDX_W-1:0]        pick_idx;
   logic                    pick_clr, show_issue;

   assign wr       = '{idx: px.px_index, rgb: px.px_rgb};
   assign wr_idx   = wr.idx[IDX_W-1:0];
   assign px.px_ready = !rst;
   assign accept   = px.px_valid && px.px_ready && (int'(wr.idx) < NUM_PIXELS);

   assign i2c.i2c_enable           = en_q;
   assign i2c.i2c_read_write       = 1'b0;
   assign i2c.i2c_device_address   = DEVICE_ADDR;
   assign i2c.i2c_divider          = I2C_DIVIDER;
   assign i2c.i2c_register_address = reg_q;
   assign i2c.i2c_mosi_data        = mosi_q;

   assign init_done_o = init_done_q;
   assign error_o     = error_q;
   assign idle_o      = (state_q == ST_IDLE) && (dirty_q == '0) && !flush_pend_q;

   rr_dirty_picker #(.NUM_PIXELS(NUM_PIXELS), .IDX_W(IDX_W)) u_picker (
      .dirty_i  (dirty_q),
      .rr_ptr_i (rr_ptr_q),
      .any_o    (pick_any),
      .idx_o    (pick_idx)
   );

   assign pick_clr   = (state_q == ST_PICK) && pick_any;
   assign show_issue = (state_q == ST_SHOW);

   // A new write to the index being picked re-arms its dirty bit.
   always_comb begin
      dirty_d = dirty_q;
      if (pick_clr) dirty_d[pick_idx] = 1'b0;
      if (accept)   dirty_d[wr_idx]   = 1'b1;
      flush_pend_d = (flush_pend_q && !show_issue) || px.flush;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dirty_q      <= '0;
         flush_pend_q <= 1'b0;
         for (int i = 0; i < NUM_PIXELS; i++) rgb_q[i] <= '0;
      end else begin
         dirty_q      <= dirty_d;
         flush_pend_q <= flush_pend_d;
         if (accept) rgb_q[wr_idx] <= wr.rgb;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_STARTUP;
         kind_q      <= TXN_PIN;
         timer_q     <= '0;
         rr_ptr_q    <= '0;
         batch_cnt_q <= '0;
         en_q        <= 1'b0;
         reg_q       <= '0;
         mosi_q      <= '0;
         init_done_q <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         en_q <= 1'b0;
         case (state_q)
            ST_STARTUP: begin
               if (timer_q == 32'(STARTUP_CYCLES - 1)) begin
                  timer_q <= '0;
                  state_q <= ST_INIT_PIN;
               end else begin
                  timer_q <= timer_q + 32'd1;
               end
            end
            ST_INIT_PIN: begin
               reg_q   <= SEESAW_NEOPIXEL_PIN;
               mosi_q  <= {NEOPIXEL_PIN, 32'h0};
               kind_q  <= TXN_PIN;
               en_q    <= 1'b1;
               state_q <= ST_ISSUE;
            end
            ST_INIT_LEN: begin
               reg_q   <= SEESAW_NEOPIXEL_BUF_LENGTH;
               mosi_q  <= {16'(NUM_PIXELS * 3), 24'h0};
               kind_q  <= TXN_LEN;
               en_q    <= 1'b1;
               state_q <= ST_ISSUE;
            end
            ST_IDLE: begin
               if (dirty_q != '0)                              state_q <= ST_PICK;
               else if (batch_cnt_q != '0 || flush_pend_q)     state_q <= ST_SHOW;
            end
            ST_PICK: begin
               if (pick_any) begin
                  reg_q       <= SEESAW_NEOPIXEL_BUF;
                  mosi_q      <= buf_payload(16'(pick_idx) * 16'd3, rgb_q[pick_idx]);
                  rr_ptr_q    <= (pick_idx == IDX_W'(NUM_PIXELS - 1)) ? '0 : pick_idx + IDX_W'(1);
                  batch_cnt_q <= batch_cnt_q + BATCH_W'(1);
                  kind_q      <= TXN_PIX;
                  en_q        <= 1'b1;
                  state_q     <= ST_ISSUE;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_SHOW: begin
               reg_q   <= SEESAW_NEOPIXEL_SHOW;
               mosi_q  <= '0;
               kind_q  <= TXN_SHOW;
               en_q    <= 1'b1;
               state_q <= ST_ISSUE;
            end
            ST_ISSUE: begin
               timer_q <= '0;
               state_q <= ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
               // A master that never goes busy is flagged and the transaction is abandoned as done.
               if (i2c.i2c_busy) begin
                  state_q <= ST_WAIT_DONE;
               end else if (timer_q == 32'(ACK_TIMEOUT - 1)) begin
                  error_q <= 1'b1;
                  state_q <= ST_FINISH;
               end else begin
                  timer_q <= timer_q + 32'd1;
               end
            end
            ST_WAIT_DONE: begin
               if (!i2c.i2c_busy) state_q <= ST_FINISH;
            end
            ST_FINISH: begin
               case (kind_q)
                  TXN_PIN: state_q <= ST_INIT_LEN;
                  TXN_LEN: begin
                     init_done_q <= 1'b1;
                     state_q     <= ST_IDLE;
                  end
                  TXN_PIX: begin
                     if (batch_cnt_q == BATCH_W'(MAX_BATCH) || dirty_q == '0) state_q <= ST_SHOW;
                     else                                                      state_q <= ST_IDLE;
                  end
                  default: begin
                     batch_cnt_q <= '0;
                     state_q     <= ST_IDLE;
                  end
               endcase
            end
            default: state_q <= ST_STARTUP;
         endcase
      end
   end

endmodule

// File: tb/tb_neotrellis_pixel_scheduler.sv
// Directed + randomized bench: i2c_master busy model, transaction-level reference of the scheduler.
module tb_neotrellis_pixel_scheduler;

   localparam int STARTUP  = 10;
   localparam int ACK_TO   = 64;
   localparam int MAXB     = 4;
   localparam int BUSY_LEN = 200;
   localparam int NPX      = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   neotrellis_px_if  px ();
   neotrellis_i2c_if i2c ();
   logic init_done, idle, error;

   neotrellis_pixel_scheduler #(
      .NUM_PIXELS(NPX), .DEVICE_ADDR(7'h2E), .I2C_DIVIDER(16'd29), .NEOPIXEL_PIN(8'd3),
      .STARTUP_CYCLES(STARTUP), .ACK_TIMEOUT(ACK_TO), .MAX_BATCH(MAXB)
   ) dut (
      .clk(clk), .rst(rst), .px(px), .i2c(i2c),
      .init_done_o(init_done), .idle_o(idle), .error_o(error)
   );

   int errors = 0;
   int checks = 0;

   typedef struct { logic [15:0] r; logic [39:0] d; } txn_t;
   txn_t obs_q[$];
   txn_t end_q[$];
   txn_t exp_q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   logic [23:0] m_rgb [NPX];
   bit          m_dirty [NPX];
   int          m_ptr, m_batch;
   bit          m_flush;

   function automatic void m_reset();
      for (int i = 0; i < NPX; i++) begin m_rgb[i] = '0; m_dirty[i] = 0; end
      m_ptr = 0; m_batch = 0; m_flush = 0;
   endfunction

   function automatic void m_write(input int i, input logic [23:0] c);
      m_rgb[i] = c; m_dirty[i] = 1;
   endfunction

   function automatic int m_any();
      int n = 0;
      for (int i = 0; i < NPX; i++) n += int'(m_dirty[i]);
      return n;
   endfunction

   function automatic void m_push(input logic [15:0] r, input logic [39:0] d);
      exp_q.push_back('{r, d});
   endfunction

   function automatic void m_init();
      m_push(16'h0E01, 40'h03_0000_0000);
      m_push(16'h0E03, {16'(NPX * 3), 24'h0});
   endfunction

   function automatic void m_pick();
      for (int k = 0; k < NPX; k++) begin
         int i = (m_ptr + k) % NPX;
         if (m_dirty[i]) begin
            m_push(16'h0E04, {16'(i * 3), m_rgb[i]});
            m_dirty[i] = 0;
            m_ptr = (i + 1) % NPX;
            m_batch++;
            return;
         end
      end
   endfunction

   function automatic void m_show();
      m_push(16'h0E05, 40'h0);
      m_batch = 0; m_flush = 0;
   endfunction

   function automatic void m_after_write();
      if (m_batch == MAXB || m_any() == 0) m_show();
   endfunction

   function automatic void m_drain();
      while (m_any() != 0) begin m_pick(); m_after_write(); end
      if (m_flush || m_batch != 0) m_show();
   endfunction

   // ---------------- i2c_master busy model ----------------
   bit hold_low = 0;
   int pend = 0, bcnt = 0;

   initial begin
      i2c.i2c_busy = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (rst) begin
            i2c.i2c_busy = 1'b0; pend = 0; bcnt = 0;
         end else begin
            if (bcnt > 0) begin
               bcnt--;
               if (bcnt == 0) begin
                  i2c.i2c_busy = 1'b0;
                  end_q.push_back('{i2c.i2c_register_address, i2c.i2c_mosi_data});
               end
            end
            if (pend > 0) begin
               pend--;
               if (pend == 0) begin i2c.i2c_busy = 1'b1; bcnt = BUSY_LEN; end
            end
            if (i2c.i2c_enable === 1'b1) begin
               obs_q.push_back('{i2c.i2c_register_address, i2c.i2c_mosi_data});
               if (hold_low) hold_low = 0;
               else          pend = 3;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic px_wr(input int i, input logic [23:0] c);
      @(negedge clk);
      px.px_valid = 1'b1; px.px_index = 4'(i); px.px_rgb = c;
      @(negedge clk);
      px.px_valid = 1'b0;
   endtask

   task automatic pulse_flush();
      @(negedge clk); px.flush = 1'b1;
      @(negedge clk); px.flush = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int stable = 0;
      int n = 0;
      while (stable < 5 && n < 20000) begin
         @(posedge clk); #1; n++;
         if (idle === 1'b1 && i2c.i2c_busy === 1'b0 && pend == 0) stable++;
         else stable = 0;
      end
      chk({tag, "_reach_idle"}, 64'(stable >= 5), 64'd1);
   endtask

   task automatic wait_busy(input string tag);
      int n = 0;
      while (i2c.i2c_busy !== 1'b1 && n < 2000) begin @(posedge clk); #1; n++; end
      chk({tag, "_busy_seen"}, 64'(i2c.i2c_busy === 1'b1), 64'd1);
   endtask

   task automatic cmp_txns(input string tag, input bit with_end);
      chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         chk($sformatf("%s_reg%0d", tag, i), 64'(obs_q[i].r), 64'(exp_q[i].r));
         chk($sformatf("%s_mosi%0d", tag, i), 64'(obs_q[i].d), 64'(exp_q[i].d));
         if (with_end && i < end_q.size())
            chk($sformatf("%s_held%0d", tag, i), 64'(end_q[i].d), 64'(exp_q[i].d));
      end
      if (with_end) chk({tag, "_end_count"}, 64'(end_q.size()), 64'(exp_q.size()));
      obs_q.delete(); end_q.delete(); exp_q.delete();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_enable"},    64'(i2c.i2c_enable), 64'd0);
      chk({tag, "_init_done"}, 64'(init_done), 64'd0);
      chk({tag, "_idle"},      64'(idle), 64'd0);
      chk({tag, "_error"},     64'(error), 64'd0);
      chk({tag, "_px_ready"},  64'(px.px_ready), 64'd0);
      chk({tag, "_reg"},       64'(i2c.i2c_register_address), 64'd0);
      chk({tag, "_mosi"},      64'(i2c.i2c_mosi_data), 64'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int lat, perm [NPX], tmp, j, n, idx;
      logic [23:0] c;

      px.px_valid = 1'b0; px.px_index = '0; px.px_rgb = '0; px.flush = 1'b0;
      m_reset();

      cyc(3); #1;
      chk_reset_outputs("rst0");
      chk("rst0_rw",   64'(i2c.i2c_read_write), 64'd0);
      chk("rst0_addr", 64'(i2c.i2c_device_address), 64'h2E);
      chk("rst0_div",  64'(i2c.i2c_divider), 64'd29);

      @(negedge clk) rst = 1'b0;
      lat = 0;
      while (i2c.i2c_enable !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
      chk("startup_latency", 64'(lat >= STARTUP && lat <= STARTUP + 3), 64'd1);
      m_init();
      wait_idle("init");
      cmp_txns("init", 1);
      chk("init_done", 64'(init_done), 64'd1);
      chk("init_idle", 64'(idle), 64'd1);

      m_write(1, 24'h0000FF); m_drain();
      px_wr(1, 24'h0000FF);
      wait_idle("px1");
      cmp_txns("px1", 1);

      c = 24'($urandom); m_write(2, c); m_drain();
      px_wr(2, c);
      wait_idle("px2");
      cmp_txns("px2", 1);

      // Burst lands while a flush SHOW is on the bus, so all three are dirty together (rr_ptr = 3).
      m_flush = 1; m_drain();
      pulse_flush();
      wait_busy("burst");
      foreach (perm[k]) perm[k] = k;
      for (int k = 0; k < 3; k++) begin
         idx = (k == 0) ? 5 : (k == 1) ? 2 : 9;
         c = 24'($urandom); m_write(idx, c); px_wr(idx, c);
      end
      m_drain();
      wait_idle("burst");
      cmp_txns("burst", 1);

      m_flush = 1; m_drain();
      pulse_flush();
      wait_idle("flush_only");
      cmp_txns("flush_only", 1);

      m_flush = 1; m_drain();
      pulse_flush();
      wait_busy("six");
      for (int k = NPX - 1; k > 0; k--) begin
         j = $urandom_range(0, k); tmp = perm[k]; perm[k] = perm[j]; perm[j] = tmp;
      end
      for (int k = 0; k < 6; k++) begin
         c = 24'($urandom); m_write(perm[k], c); px_wr(perm[k], c);
      end
      m_drain();
      wait_idle("six");
      cmp_txns("six", 1);

      c = 24'($urandom); m_write(2, c); m_pick();
      px_wr(2, c);
      wait_busy("rewrite");
      cyc(10);
      px_wr(2, 24'h112233); m_write(2, 24'h112233);
      m_after_write(); m_drain();
      wait_idle("rewrite");
      cmp_txns("rewrite", 1);

      for (int r = 0; r < 3; r++) begin
         m_flush = 1; m_drain();
         pulse_flush();
         wait_busy($sformatf("rand%0d", r));
         n = $urandom_range(1, 9);
         for (int k = 0; k < n; k++) begin
            idx = $urandom_range(0, NPX - 1); c = 24'($urandom);
            m_write(idx, c); px_wr(idx, c);
         end
         m_drain();
         wait_idle($sformatf("rand%0d", r));
         cmp_txns($sformatf("rand%0d", r), 1);
      end

      chk("pre_timeout_error", 64'(error), 64'd0);
      hold_low = 1;
      idx = $urandom_range(0, NPX - 1); c = 24'($urandom);
      m_write(idx, c); m_drain();
      px_wr(idx, c);
      wait_idle("timeout");
      cmp_txns("timeout", 0);
      chk("timeout_error", 64'(error), 64'd1);

      idx = $urandom_range(0, NPX - 1); c = 24'($urandom);
      px_wr(idx, c);
      wait_busy("midrst");
      cyc(20);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      chk_reset_outputs("midrst");
      cyc(2);
      obs_q.delete(); end_q.delete(); exp_q.delete();
      m_reset(); m_init();
      @(negedge clk) rst = 1'b0;
      wait_idle("reinit");
      cmp_txns("reinit", 1);
      chk("reinit_done",  64'(init_done), 64'd1);
      chk("reinit_error", 64'(error), 64'd0);

      idx = $urandom_range(0, NPX - 1); c = 24'($urandom);
      m_write(idx, c); m_drain();
      px_wr(idx, c);
      wait_idle("post_rst");
      cmp_txns("post_rst", 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
